// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared types and byte/keep helpers for the header inserter
package axis_hdr_pkg;

  // Widest bus the helpers cover; callers cast results down to their own width.
  localparam int MAX_BYTES = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // MSB-aligned run of n ones inside an nbytes-wide field held in the low bits.
  function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input int n, input int nbytes);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i >= nbytes - n)) k[i] = 1'b1;
    end
    return k;
  endfunction

  // LSB-aligned run of n ones.
  function automatic logic [MAX_BYTES-1:0] low_bytes(input int n);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n) k[i] = 1'b1;
    end
    return k;
  endfunction

  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) c += int'(v[i]);
    return c;
  endfunction

  // Expands a per-byte enable into a per-bit data mask.
  function automatic logic [8*MAX_BYTES-1:0] byte_mask(input logic [MAX_BYTES-1:0] keep);
    logic [8*MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_merger.sv
// rtl/axis_byte_merger.sv - combinational residue/payload byte realignment
module axis_byte_merger
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      residue,
  input  logic [BYTE_CNT_WD-1:0]  hdr_cnt,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  output logic [DATA_WD-1:0]      merged_data,
  output logic [DATA_BYTE_WD-1:0] merged_keep,
  output logic [DATA_WD-1:0]      new_residue,
  output logic [DATA_BYTE_WD-1:0] flush_keep,
  output logic                    needs_flush
);

  int h;
  int k;

  // Residue bytes lead, the top of the new beat fills the rest; the low h bytes carry over.
  always_comb begin
    h           = int'(hdr_cnt);
    k           = popcount(MAX_BYTES'(keep_in));
    needs_flush = (h + k) > DATA_BYTE_WD;
    merged_keep = needs_flush ? '1 : DATA_BYTE_WD'(keep_from_cnt(h + k, DATA_BYTE_WD));
    merged_data = ((residue << (8 * (DATA_BYTE_WD - h))) | (data_in >> (8 * h)))
                  & DATA_WD'(byte_mask(MAX_BYTES'(merged_keep)));
    new_residue = data_in & DATA_WD'(byte_mask(low_bytes(h)));
    flush_keep  = needs_flush ? DATA_BYTE_WD'(keep_from_cnt(h + k - DATA_BYTE_WD, DATA_BYTE_WD)) : '0;
  end

endmodule

// File: rtl/axi_stream_insert_header_v2.sv
// rtl/axi_stream_insert_header_v2.sv - prepends a 0..DATA_BYTE_WD byte header to each packet
module axi_stream_insert_header_v2
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    hdr_err
);

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  h_q;
  logic [DATA_WD-1:0]      r_q;
  logic [DATA_BYTE_WD-1:0] fkeep_q;

  logic [DATA_WD-1:0]      m_data;
  logic [DATA_BYTE_WD-1:0] m_keep;
  logic [DATA_WD-1:0]      m_res;
  logic [DATA_BYTE_WD-1:0] m_fkeep;
  logic                    m_flush;

  logic                    out_free;
  logic                    hdr_fire, beat_fire, flush_fire;
  logic [BYTE_CNT_WD-1:0]  h_clamped;
  logic                    hdr_bad;
  logic [DATA_WD-1:0]      flush_data;

  axis_byte_merger #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_merger (
    .residue     (r_q),
    .hdr_cnt     (h_q),
    .data_in     (data_in),
    .keep_in     (keep_in),
    .merged_data (m_data),
    .merged_keep (m_keep),
    .new_residue (m_res),
    .flush_keep  (m_fkeep),
    .needs_flush (m_flush)
  );

  assign out_free   = !valid_out || ready_out;
  assign h_clamped  = (int'(byte_insert_cnt) > DATA_BYTE_WD) ? BYTE_CNT_WD'(DATA_BYTE_WD) : byte_insert_cnt;
  assign hdr_bad    = (popcount(MAX_BYTES'(keep_insert)) != int'(byte_insert_cnt))
                      || (int'(byte_insert_cnt) > DATA_BYTE_WD);
  assign flush_data = (r_q << (8 * (DATA_BYTE_WD - int'(h_q))))
                      & DATA_WD'(byte_mask(MAX_BYTES'(fkeep_q)));

  // Next state and handshakes; the output register is the only buffering.
  always_comb begin
    state_d      = state_q;
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    hdr_fire     = 1'b0;
    beat_fire    = 1'b0;
    flush_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) begin
          hdr_fire = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          beat_fire = 1'b1;
          if (last_in) state_d = m_flush ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (out_free) begin
          flush_fire = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, header length, carried residue and the pending tail keep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      r_q     <= '0;
      fkeep_q <= '0;
      hdr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_err <= hdr_fire && hdr_bad;
      if (hdr_fire) begin
        h_q <= h_clamped;
        r_q <= data_insert & DATA_WD'(byte_mask(low_bytes(int'(h_clamped))));
      end else if (beat_fire) begin
        r_q <= m_res;
        if (last_in) fkeep_q <= m_fkeep;
      end
    end
  end

  // Output register: loads on a merged beat or the tail flush, clears after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (beat_fire) begin
      valid_out <= 1'b1;
      data_out  <= m_data;
      keep_out  <= m_keep;
      last_out  <= last_in && !m_flush;
    end else if (flush_fire) begin
      valid_out <= 1'b1;
      data_out  <= flush_data;
      keep_out  <= fkeep_q;
      last_out  <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header_v2.sv
// tb/tb_axi_stream_insert_header_v2.sv - scoreboard bench for the header inserter
module tb_axi_stream_insert_header_v2;

  localparam int DATA_WD = 32;
  localparam int NB      = DATA_WD / 8;
  localparam int CW      = $clog2(NB) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [DATA_WD-1:0] data_in;
  logic [NB-1:0]     keep_in;
  logic              last_in;
  logic              ready_in;
  logic              valid_insert;
  logic [DATA_WD-1:0] data_insert;
  logic [NB-1:0]     keep_insert;
  logic [CW-1:0]     byte_insert_cnt;
  logic              ready_insert;
  logic              valid_out;
  logic [DATA_WD-1:0] data_out;
  logic [NB-1:0]     keep_out;
  logic              last_out;
  logic              ready_out;
  logic              hdr_err;

  always #5 clk = ~clk;

  axi_stream_insert_header_v2 #(.DATA_WD(DATA_WD)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .hdr_err         (hdr_err)
  );

  typedef struct {
    logic [DATA_WD-1:0] data;
    logic [NB-1:0]      keep;
    logic               last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_err_pulses = 0;
  int    seen_err_pulses = 0;
  bit    mon_en = 1'b1;
  int    rmode = 0;
  bit    gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NB-1:0] kmsb(input int k);
    logic [NB-1:0] m;
    m = '0;
    for (int j = 0; j < k; j++) m[NB-1-j] = 1'b1;
    return m;
  endfunction

  function automatic logic [NB-1:0] klsb(input int k);
    logic [NB-1:0] m;
    m = '0;
    for (int j = 0; j < k; j++) m[j] = 1'b1;
    return m;
  endfunction

  // Reference: concatenate header bytes and payload bytes, then cut into bus-wide beats.
  task automatic model_packet(input int h, input logic [DATA_WD-1:0] hdr,
                              input logic [DATA_WD-1:0] pl[$], input int lastk);
    logic [7:0] bq[$];
    beat_t      b;
    int         k;
    for (int j = 0; j < h; j++) bq.push_back(hdr[8*(h-1-j) +: 8]);
    for (int i = 0; i < pl.size(); i++) begin
      k = (i == pl.size() - 1) ? lastk : NB;
      for (int j = 0; j < k; j++) bq.push_back(pl[i][DATA_WD-1-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < NB && bq.size() > 0; j++) begin
        b.data[DATA_WD-1-8*j -: 8] = bq.pop_front();
        b.keep[NB-1-j] = 1'b1;
      end
      b.last = (bq.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic timeout(input string what);
    errors++;
    $display("FAIL timeout_%s actual=stuck required=handshake", what);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  endtask

  // Entered at a negedge; header and first beat are offered together.
  task automatic send_packet(input int cnt, input logic [DATA_WD-1:0] hdr, input logic [NB-1:0] kins,
                             input logic [DATA_WD-1:0] pl[$], input int lastk);
    int h, n;
    h = (cnt > NB) ? NB : cnt;
    if (($countones(kins) != cnt) || (cnt > NB)) exp_err_pulses++;
    model_packet(h, hdr, pl, lastk);
    valid_insert    = 1'b1;
    data_insert     = hdr;
    keep_insert     = kins;
    byte_insert_cnt = CW'(cnt);
    valid_in        = 1'b1;
    data_in         = pl[0];
    keep_in         = (pl.size() == 1) ? kmsb(lastk) : '1;
    last_in         = (pl.size() == 1);
    n = 0;
    while (!ready_insert) begin
      @(negedge clk);
      n++;
      if (n > 1000) timeout("hdr");
    end
    @(negedge clk);
    valid_insert = 1'b0;
    data_insert  = $urandom;
    for (int i = 0; i < pl.size(); i++) begin
      valid_in = 1'b1;
      data_in  = pl[i];
      keep_in  = (i == pl.size() - 1) ? kmsb(lastk) : '1;
      last_in  = (i == pl.size() - 1);
      n = 0;
      while (!ready_in) begin
        @(negedge clk);
        n++;
        if (n > 1000) timeout("beat");
      end
      @(negedge clk);
      valid_in = 1'b0;
      keep_in  = NB'($urandom);
      last_in  = 1'($urandom);
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
    end
  endtask

  // Downstream ready pattern, changed well away from both clock edges.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       ready_out = 1'b1;
        1:       ready_out = ($urandom_range(0, 2) != 0);
        default: ready_out = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall hold.
  initial begin
    beat_t             e;
    bit                hold_v;
    logic [DATA_WD-1:0] hd;
    logic [NB-1:0]     hk;
    logic              hl;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en || rst) begin
        hold_v = 1'b0;
      end else begin
        if (hdr_err) seen_err_pulses++;
        if (hold_v) begin
          check("hold_valid", valid_out, 1'b1);
          check("hold_data", data_out, hd);
          check("hold_keep", keep_out, hk);
          check("hold_last", last_out, hl);
        end
        if (valid_out && ready_out) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", data_out);
          end else begin
            e = exp_q.pop_front();
            check("data_out", data_out, e.data);
            check("keep_out", keep_out, e.keep);
            check("last_out", last_out, e.last);
          end
        end else if (valid_out) begin
          hold_v = 1'b1;
          hd = data_out;
          hk = keep_out;
          hl = last_out;
          check("stall_ready_in", ready_in, 1'b0);
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [DATA_WD-1:0] pl[$];
    int cnt, nb, lk, n;
    logic [NB-1:0] kins;

    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    #1;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_last_out", last_out, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_keep_out", keep_out, '0);
    check("rst_hdr_err", hdr_err, 1'b0);
    check("rst_ready_insert", ready_insert, 1'b1);
    check("rst_ready_in", ready_in, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pl = '{32'h11223344, 32'h55667788};
    send_packet(2, 32'h0000AABB, 4'b0011, pl, 2);
    pl = '{32'h11223344};
    send_packet(3, 32'h00CCDDEE, 4'b0111, pl, 3);
    pl = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    send_packet(0, 32'h12345678, 4'b0000, pl, 4);
    pl = '{32'hD1D2D3D4, 32'hE1E2E3E4};
    send_packet(0, 32'h12345678, 4'b0000, pl, 1);
    pl = '{32'h01020304};
    send_packet(4, 32'hDEADBEEF, 4'b1111, pl, 4);
    pl = '{32'h99887766, 32'h55443322};
    send_packet(3, 32'h00F1F2F3, 4'b0011, pl, 2);
    pl = '{32'h0A0B0C0D};
    send_packet(5, 32'h76543210, 4'b1111, pl, 3);

    pl = '{32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243};
    fork
      send_packet(1, 32'h0000007E, 4'b0001, pl, 3);
      begin
        repeat (3) @(posedge clk);
        rmode = 2;
        repeat (5) @(posedge clk);
        rmode = 0;
      end
    join

    rmode = 1;
    gaps  = 1'b1;
    for (int p = 0; p < 200; p++) begin
      cnt  = $urandom_range(0, NB);
      kins = klsb(cnt);
      if ($urandom_range(0, 15) == 0) kins = NB'($urandom);
      nb = $urandom_range(1, 4);
      lk = $urandom_range(1, NB);
      pl.delete();
      for (int i = 0; i < nb; i++) pl.push_back($urandom);
      send_packet(cnt, $urandom, kins, pl, lk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("hdr_err_pulses", seen_err_pulses, exp_err_pulses);

    rmode = 2;
    gaps  = 1'b0;
    repeat (2) @(negedge clk);
    pl = '{32'hCAFEF00D, 32'h0BADBEEF, 32'h12121212};
    fork
      send_packet(2, 32'h00005A5A, 4'b0011, pl, 4);
    join_none
    n = 0;
    while (!valid_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_valid", valid_out, 1'b1);
    mon_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid_out, 1'b0);
    check("async_rst_data", data_out, '0);
    check("async_rst_keep", keep_out, '0);
    check("async_rst_last", last_out, 1'b0);
    disable fork;
    valid_in = 1'b0;
    valid_insert = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_insert", ready_insert, 1'b1);
    check("post_rst_ready_in", ready_in, 1'b0);
    check("post_rst_valid", valid_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
